unibus_oc_master: RTL

Bus-master cycle engine for the open-collector, active-low backplane bus whose lines are held high by the RES20 pull-up packs. It turns a single-word read/write request from the processor side into an MSYN/SSYN interlocked bus transfer: it pulls address, data, C1 and MSYN lines low, waits for the slave's SSYN, and releases lines back to the pull-ups. It sits directly upstream of the pull-up packs and bus drivers; every bus output is a "pull" enable, never a driven high.

---
 rtl/unibus_oc_master_pkg.sv | 25 ++
 rtl/unibus_oc_master_sync2.sv | 35 +++
 rtl/unibus_oc_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/unibus_oc_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unibus_oc_master_pkg
//  Description : Shared types and default widths for the open-collector
//                backplane bus blocks (master, slave side, arbiter).
//  Revision    : 1.0 - initial release
// ============================================================================
package unibus_oc_master_pkg;

  // Default backplane widths, shared with the slave-side and arbiter blocks
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  // Bus-master cycle states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_MSYN    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/unibus_oc_master_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : unibus_oc_master_sync2
//  Description : Two-flop synchronizer with a programmable reset value.
//                Used for SSYN here and for bus-grant inputs elsewhere.
//  Revision    : 1.0 - initial release
// ============================================================================
module unibus_oc_master_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/unibus_oc_master.sv
`default_nettype none
// ============================================================================
//  Module      : unibus_oc_master
//  Description : Bus-master cycle engine for the open-collector, active-low
//                backplane. Runs one MSYN/SSYN interlocked DATI/DATO transfer
//                per request. Every bus output is a pull-low enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module unibus_oc_master
  import unibus_oc_master_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DESKEW  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bus_a_pull,
  output logic [DATA_W-1:0] bus_d_pull,
  output logic              bus_c1_pull,
  output logic              bus_msyn_pull,
  input  logic [DATA_W-1:0] bus_d_n,
  input  logic              bus_ssyn_n
);

  // One counter serves both the deskew delay and the SSYN timeouts
  localparam int c_cnt_max = (TIMEOUT > DESKEW) ? TIMEOUT : DESKEW;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_deskew_ld  = c_cnt_w'(DESKEW - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_ld = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_next_cnt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_capture;
  logic                w_accept;
  logic                w_ssyn_n_sync;
  logic                w_ssyn_s;

  // SSYN comes from another clock domain; reset value is "negated" (line high)
  unibus_oc_master_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_ssyn_sync (
    .clk (clk),
    .rst (reset),
    .i_d (bus_ssyn_n),
    .o_q (w_ssyn_n_sync)
  );

  assign w_ssyn_s = ~w_ssyn_n_sync;
  assign w_accept = (r_state == ST_IDLE) && req;

  // State and counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Request capture and read-data holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_wr    <= wr;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      // Data lines are inverted sense: low on the line is a logic 1
      if (w_capture) begin
        r_rdata <= ~bus_d_n;
      end
    end
  end

  // Next-state, counter and bus pull decode
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_capture     = 1'b0;
    bus_a_pull    = '0;
    bus_d_pull    = '0;
    bus_c1_pull   = 1'b0;
    bus_msyn_pull = 1'b0;
    ack           = 1'b0;
    err           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_next_state = ST_SETUP;
          w_next_cnt   = c_deskew_ld;
        end
      end

      ST_SETUP: begin
        bus_a_pull  = r_addr;
        bus_c1_pull = r_wr;
        bus_d_pull  = r_wr ? r_wdata : '0;
        if (r_cnt == '0) begin
          w_next_state = ST_MSYN;
          w_next_cnt   = c_timeout_ld;
        end else begin
          w_next_cnt   = r_cnt - c_cnt_one;
        end
      end

      ST_MSYN: begin
        bus_a_pull    = r_addr;
        bus_c1_pull   = r_wr;
        bus_d_pull    = r_wr ? r_wdata : '0;
        bus_msyn_pull = 1'b1;
        if (w_ssyn_s) begin
          w_capture    = ~r_wr;
          w_next_state = ST_RELEASE;
          w_next_cnt   = c_timeout_ld;
        end else if (r_cnt == '0) begin
          w_next_state = ST_ERR;
        end else begin
          w_next_cnt   = r_cnt - c_cnt_one;
        end
      end

      ST_RELEASE: begin
        // Address/data/C1 stay on the bus until the slave drops SSYN
        bus_a_pull  = r_addr;
        bus_c1_pull = r_wr;
        bus_d_pull  = r_wr ? r_wdata : '0;
        if (!w_ssyn_s) begin
          w_next_state = ST_DONE;
        end else if (r_cnt == '0) begin
          w_next_state = ST_ERR;
        end else begin
          w_next_cnt   = r_cnt - c_cnt_one;
        end
      end

      ST_DONE: begin
        ack          = 1'b1;
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end

      ST_ERR: begin
        ack          = 1'b1;
        err          = 1'b1;
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end

      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign busy  = (r_state != ST_IDLE);
  assign rdata = r_rdata;

endmodule
`default_nettype wire
